// File: rtl/cdc_word_rx_pkg.sv
// Shared definitions for the clk-domain side of the 4-phase req/ack word transfer.
// State encodings are kept as plain 2-bit constants so a future transmitter can share them.
package cdc_word_rx_pkg;

  localparam logic [1:0] S_FLUSH = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  // Width needed to count from 0 up to and including the timeout limit.
  function automatic int tcnt_width(input int timeout);
    if (timeout < 1) return 1;
    return $clog2(timeout + 1);
  endfunction

  typedef struct packed {
    logic [1:0] state;
    logic       req_s;
    logic       primed;
  } rx_dbg_t;

endpackage

// File: rtl/cdc_word_rx_if.sv
// Bundle of the foreign-side req/ack/data lines and the local valid/ready output stream.
// Stream rule: a word moves on any clk edge where out_valid && out_ready; once raised,
// out_valid and out_data hold steady until that edge, and out_valid never waits on out_ready.
interface cdc_word_rx_if #(
  parameter int W = 32
);
  logic         async_req;
  logic [W-1:0] async_data;
  logic         async_ack;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output async_req, async_data, out_ready,
    input  async_ack, out_data, out_valid
  );

  modport slave (
    input  async_req, async_data, out_ready,
    output async_ack, out_data, out_valid
  );
endinterface

// File: rtl/cdc_word_rx_sync.sv
// Multi-flop synchronizer for level signals arriving from another clock domain.
// Every stage clears on reset, so q reads 0 until NSYNC edges after reset release.
module cdc_word_rx_sync #(
  parameter int NOUT  = 1,
  parameter int NSYNC = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NOUT-1:0] d,
  output logic [NOUT-1:0] q
);

  logic [NOUT-1:0] chain [NSYNC];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NSYNC; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < NSYNC; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[NSYNC-1];

endmodule

// File: rtl/cdc_word_rx.sv
// Receive controller: synchronizes async_req, captures async_data on the capture edge,
// answers with a level ack and presents the word on a valid/ready stream.
module cdc_word_rx
  import cdc_word_rx_pkg::*;
#(
  parameter int W       = 32,
  parameter int NSYNC   = 2,
  parameter int TIMEOUT = 1023,
  parameter int CNTW    = 16
) (
  input  logic            clk,
  input  logic            reset,
  cdc_word_rx_if.slave    bus,
  output logic            busy,
  output logic            err_timeout,
  input  logic            err_clr,
  output logic [CNTW-1:0] xfer_cnt,
  output rx_dbg_t         dbg
);

  localparam int             TW     = tcnt_width(TIMEOUT);
  localparam logic [TW-1:0]  T_MAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT - 1);

  logic [1:0]       state;
  logic             req_s;
  logic [NSYNC-1:0] prime;
  logic [TW-1:0]    tcnt;
  logic             ack_q;
  logic             valid_q;
  logic [W-1:0]     data_q;
  logic             err_q;
  logic [CNTW-1:0]  cnt_q;

  logic buf_free;
  logic capture;
  logic to_set;

  cdc_word_rx_sync #(.NOUT(1), .NSYNC(NSYNC)) u_req_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.async_req),
    .q     (req_s)
  );

  // A word may be taken in the same cycle the previous one drains.
  assign buf_free = !valid_q || bus.out_ready;
  assign capture  = (state == S_IDLE) && req_s && buf_free;
  assign to_set   = (state == S_WAIT) && req_s && (tcnt == T_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FLUSH;
      prime   <= '0;
      tcnt    <= '0;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // Ones walk through prime in step with the cleared sync chain; once the top bit
      // is set, req_s reflects the real async_req rather than its reset value.
      prime <= {prime[NSYNC-2:0], 1'b1};

      if (capture) begin
        data_q  <= bus.async_data;
        valid_q <= 1'b1;
        cnt_q   <= cnt_q + 1'b1;
      end else if (bus.out_ready) begin
        valid_q <= 1'b0;
      end

      if (to_set)       err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;

      case (state)
        // A req that survived a reset must drop before anything is captured again.
        S_FLUSH: if (prime[NSYNC-1] && !req_s) state <= S_IDLE;
        S_IDLE: begin
          if (capture) begin
            ack_q <= 1'b1;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!req_s) begin
            ack_q <= 1'b0;
            tcnt  <= '0;
            state <= S_IDLE;
          end else if (tcnt != T_MAX) begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= S_FLUSH;
      endcase
    end
  end

  assign bus.async_ack = ack_q;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign busy          = (state != S_IDLE);
  assign err_timeout   = err_q;
  assign xfer_cnt      = cnt_q;
  assign dbg           = '{state: state, req_s: req_s, primed: prime[NSYNC-1]};

endmodule

// File: tb/tb_cdc_word_rx.sv
// Directed bench for cdc_word_rx (NSYNC=2, TIMEOUT=8, CNTW=4); inputs are driven and
// outputs sampled on the falling edge, so each negedge sees the result of one rising edge.
module tb_cdc_word_rx;
  import cdc_word_rx_pkg::*;

  logic       clk;
  logic       reset;
  logic       err_clr;
  logic       busy;
  logic       err_timeout;
  logic [3:0] xfer_cnt;
  rx_dbg_t    dbg;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] sb_word;
  int          rx_n;
  int          rx_cyc;
  int          n;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  exp_cnt;
  } vec_t;
  vec_t vecs[5];

  cdc_word_rx_if #(.W(32)) bus ();

  cdc_word_rx #(.W(32), .NSYNC(2), .TIMEOUT(8), .CNTW(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .busy        (busy),
    .err_timeout (err_timeout),
    .err_clr     (err_clr),
    .xfer_cnt    (xfer_cnt),
    .dbg         (dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ack(input logic val, input int budget, input string name);
    int k;
    k = 0;
    while (bus.async_ack !== val && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(bus.async_ack), 32'(val));
  endtask

  // Full 4-phase handshake from the sender's side; returns once ack has dropped.
  task automatic send_word(input logic [31:0] data, input logic push);
    wait_ack(1'b0, 50, "pre_ack_low");
    if (push) exp_q.push_back(data);
    bus.async_data = data;
    bus.async_req  = 1'b1;
    wait_ack(1'b1, 200, "ack_rise");
    bus.async_req  = 1'b0;
    wait_ack(1'b0, 50, "ack_fall");
  endtask

  initial begin
    vecs[0] = '{data: 32'h0000_0000, exp_cnt: 4'd2};
    vecs[1] = '{data: 32'hFFFF_FFFF, exp_cnt: 4'd3};
    vecs[2] = '{data: 32'hA5A5_A5A5, exp_cnt: 4'd4};
    vecs[3] = '{data: 32'h1234_5678, exp_cnt: 4'd5};
    vecs[4] = '{data: 32'h8000_0001, exp_cnt: 4'd6};

    reset          = 1'b1;
    err_clr        = 1'b0;
    bus.async_req  = 1'b0;
    bus.async_data = '0;
    bus.out_ready  = 1'b0;

    // Reset values, then flush to idle once the sync chain has filled.
    repeat (3) @(negedge clk);
    check("rst_ack",   32'(bus.async_ack), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data",  bus.out_data,       32'd0);
    check("rst_err",   32'(err_timeout),   32'd0);
    check("rst_cnt",   32'(xfer_cnt),      32'd0);
    check("rst_busy",  32'(busy),          32'd1);
    check("rst_state", 32'(dbg.state),     32'(S_FLUSH));
    reset = 1'b0;
    @(negedge clk);
    check("flush_busy_e1", 32'(busy), 32'd1);
    @(negedge clk);
    check("flush_busy_e2", 32'(busy), 32'd1);
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_state", 32'(dbg.state), 32'(S_IDLE));
    check("idle_ack", 32'(bus.async_ack), 32'd0);

    // Capture latency and release latency with the consumer always ready.
    bus.out_ready  = 1'b1;
    bus.async_data = 32'hDEAD_BEEF;
    bus.async_req  = 1'b1;
    @(negedge clk);
    check("lat_ack_k", 32'(bus.async_ack), 32'd0);
    @(negedge clk);
    check("lat_ack_k1", 32'(bus.async_ack), 32'd0);
    check("lat_valid_k1", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("lat_ack_k2", 32'(bus.async_ack), 32'd1);
    check("lat_valid_k2", 32'(bus.out_valid), 32'd1);
    check("lat_data", bus.out_data, 32'hDEAD_BEEF);
    check("lat_cnt", 32'(xfer_cnt), 32'd1);
    bus.async_req = 1'b0;
    @(negedge clk);
    check("rel_ack_j", 32'(bus.async_ack), 32'd1);
    check("rel_valid_drained", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("rel_ack_j1", 32'(bus.async_ack), 32'd1);
    @(negedge clk);
    check("rel_ack_j2", 32'(bus.async_ack), 32'd0);
    check("rel_busy", 32'(busy), 32'd0);

    // Table of words: capture with the consumer stalled, check, then drain.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_word(vecs[i].data, 1'b0);
      check($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("vec%0d_data", i), bus.out_data, vecs[i].data);
      check($sformatf("vec%0d_cnt", i), 32'(xfer_cnt), 32'(vecs[i].exp_cnt));
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check($sformatf("vec%0d_drained", i), 32'(bus.out_valid), 32'd0);
    end

    // Backpressure: second word waits, then accept and capture share one edge.
    send_word(32'h1111_AAAA, 1'b0);
    bus.async_data = 32'h2222_BBBB;
    bus.async_req  = 1'b1;
    repeat (6) @(negedge clk);
    check("bp_ack_withheld", 32'(bus.async_ack), 32'd0);
    check("bp_valid_held", 32'(bus.out_valid), 32'd1);
    check("bp_data_first", bus.out_data, 32'h1111_AAAA);
    bus.out_ready = 1'b1;
    check("bp_accept_first", bus.out_data, 32'h1111_AAAA);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp_valid_kept", 32'(bus.out_valid), 32'd1);
    check("bp_data_second", bus.out_data, 32'h2222_BBBB);
    check("bp_ack_second", 32'(bus.async_ack), 32'd1);
    check("bp_cnt", 32'(xfer_cnt), 32'd8);
    bus.async_req = 1'b0;
    wait_ack(1'b0, 20, "bp_ack_fall");
    bus.out_ready = 1'b1;
    check("bp_accept_second", bus.out_data, 32'h2222_BBBB);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp_drained", 32'(bus.out_valid), 32'd0);

    // Timeout: req held high; error sets on the 8th edge in S_WAIT, ack unaffected.
    bus.out_ready  = 1'b1;
    bus.async_data = 32'hC0FF_EE00;
    bus.async_req  = 1'b1;
    wait_ack(1'b1, 20, "to_ack_rise");
    repeat (7) @(negedge clk);
    check("to_err_before", 32'(err_timeout), 32'd0);
    @(negedge clk);
    check("to_err_set", 32'(err_timeout), 32'd1);
    check("to_ack_held", 32'(bus.async_ack), 32'd1);
    repeat (11) @(negedge clk);
    check("to_err_sticky", 32'(err_timeout), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("to_err_cleared", 32'(err_timeout), 32'd0);
    check("to_ack_still", 32'(bus.async_ack), 32'd1);
    check("to_cnt", 32'(xfer_cnt), 32'd9);
    bus.async_req = 1'b0;
    wait_ack(1'b0, 20, "to_ack_fall");
    check("to_busy_done", 32'(busy), 32'd0);
    check("to_err_stays_clear", 32'(err_timeout), 32'd0);

    // Reset mid-transfer with req still high: no recapture of the stale word.
    bus.async_data = 32'h5EED_0001;
    bus.async_req  = 1'b1;
    wait_ack(1'b1, 20, "mr_ack_rise");
    check("mr_cnt_before", 32'(xfer_cnt), 32'd10);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("mr_ack_rst", 32'(bus.async_ack), 32'd0);
    check("mr_valid_rst", 32'(bus.out_valid), 32'd0);
    check("mr_cnt_rst", 32'(xfer_cnt), 32'd0);
    repeat (10) @(negedge clk);
    check("mr_no_recapture_ack", 32'(bus.async_ack), 32'd0);
    check("mr_no_recapture_cnt", 32'(xfer_cnt), 32'd0);
    check("mr_state_flush", 32'(dbg.state), 32'(S_FLUSH));
    bus.async_req = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mr_idle_after_drop", 32'(busy), 32'd0);
    send_word(32'h0BAD_F00D, 1'b0);
    check("mr_new_cnt", 32'(xfer_cnt), 32'd1);
    check("mr_new_data", bus.out_data, 32'h0BAD_F00D);

    // Counter wrap: 16 more transfers take a 4-bit count from 1 back to 1.
    for (int i = 0; i < 16; i++) send_word(32'h0101_0101 * i, 1'b0);
    check("wrap_cnt", 32'(xfer_cnt), 32'd1);
    repeat (2) @(negedge clk);

    // Random consumer stalls against a sender running 1000 words.
    bus.out_ready = 1'b0;
    @(negedge clk);
    rx_n   = 0;
    rx_cyc = 0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          sb_word = $urandom;
          send_word(sb_word, 1'b1);
        end
      end
      begin
        while (rx_n < 1000 && rx_cyc < 60000) begin
          @(negedge clk);
          bus.out_ready = ($urandom_range(0, 3) != 0);
          if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
              check("sb_unexpected_word", bus.out_data, 32'hFFFF_FFFF ^ bus.out_data);
            end else begin
              check("sb_word", bus.out_data, exp_q.pop_front());
            end
            rx_n++;
          end
          rx_cyc++;
        end
      end
    join
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("sb_rx_count", 32'(rx_n), 32'd1000);
    check("sb_queue_empty", 32'(exp_q.size()), 32'd0);
    check("sb_final_cnt", 32'(xfer_cnt), 32'd9);
    check("sb_no_timeout", 32'(err_timeout), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
